// File: rtl/codeword_packer_pkg.sv
// Shared constants and FSM encoding for the codeword packer.
// The optional per-frame bit statistics are enabled with PACK_STATS_EN.
package codeword_packer_pkg;

    localparam int CODEWORD_MAX_LEN = 16;
    localparam int CODEWORD_LEN_W   = 5;
    localparam int PACK_OUT_W       = 32;

    typedef enum logic [1:0] {
        ACCUM      = 2'd0,
        EMIT       = 2'd1,
        FLUSH_EMIT = 2'd2
    } pack_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/codeword_packer_bit_inserter.sv
// Combinational barrel shift: places the low `length` bits of a codeword
// directly below the `fill` bits already held in the accumulator.
module codeword_packer_bit_inserter #(
    parameter int CW_W   = 16,
    parameter int LEN_W  = 5,
    parameter int ACC_W  = 48,
    parameter int FILL_W = 6
) (
    input  logic [CW_W-1:0]   codeword,
    input  logic [LEN_W-1:0]  length,
    input  logic [FILL_W-1:0] fill,
    output logic [ACC_W-1:0]  bits,
    output logic [LEN_W-1:0]  len_eff
);

    localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(CW_W);
    localparam logic [FILL_W-1:0] TOP     = FILL_W'(ACC_W);

    logic [CW_W:0]     one_hot;
    logic [CW_W-1:0]   mask;
    logic [CW_W-1:0]   masked;
    logic [FILL_W-1:0] shamt;

    always_comb begin
        len_eff = (length > MAX_LEN) ? MAX_LEN : length;
        one_hot = (CW_W+1)'(1) << len_eff;
        mask    = CW_W'(one_hot - (CW_W+1)'(1));
        masked  = codeword & mask;
        // Left-justify: the first new bit lands at ACC_W-1-fill.
        shamt   = TOP - fill - FILL_W'(len_eff);
        bits    = ACC_W'(masked) << shamt;
    end

endmodule

// File: rtl/codeword_packer.sv
// Packs variable-length codewords MSB-first into OUT_W-bit words; flush
// closes a frame with a zero-padded last word. Optional stats: PACK_STATS_EN.
module codeword_packer
    import codeword_packer_pkg::*;
#(
    parameter  int CW_W   = CODEWORD_MAX_LEN,
    parameter  int LEN_W  = CODEWORD_LEN_W,
    parameter  int OUT_W  = PACK_OUT_W,
    localparam int ACC_W  = OUT_W + CW_W,
    localparam int FILL_W = $clog2(ACC_W + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   codeword,
    input  logic [LEN_W-1:0]  length,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_last,
    output logic [FILL_W-1:0] out_bits,
    output pack_state_t       fsm_state
`ifdef PACK_STATS_EN
    ,
    output logic [15:0]       frame_bits
`endif
);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; out_valid and its payload hold until accepted.

    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_W);

    pack_state_t       state, nxt_state;
    logic [ACC_W-1:0]  acc, nxt_acc, ins_bits;
    logic [FILL_W-1:0] fill, nxt_fill, fill_ins;
    logic              flush_pend, nxt_pend;
    logic [LEN_W-1:0]  len_eff;
    logic              accept;

    logic              nxt_in_ready;
    logic              nxt_out_valid;
    logic [OUT_W-1:0]  nxt_out_data;
    logic              nxt_out_last;
    logic [FILL_W-1:0] nxt_out_bits;

    codeword_packer_bit_inserter #(
        .CW_W   (CW_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W),
        .FILL_W (FILL_W)
    ) u_inserter (
        .codeword (codeword),
        .length   (length),
        .fill     (fill),
        .bits     (ins_bits),
        .len_eff  (len_eff)
    );

    assign accept    = in_valid & in_ready;
    assign fill_ins  = fill + FILL_W'(len_eff);
    assign fsm_state = state;

    always_comb begin
        nxt_state = state;
        nxt_acc   = acc;
        nxt_fill  = fill;
        nxt_pend  = flush_pend;

        case (state)
            ACCUM: begin
                if (accept) begin
                    nxt_acc  = acc | ins_bits;
                    nxt_fill = fill_ins;
                end
                if (flush) begin
                    nxt_pend = 1'b1;
                end
                // A completed word always goes out before a pending flush.
                if (accept && (fill_ins >= OUT_W_F)) begin
                    nxt_state = EMIT;
                end else if (nxt_pend) begin
                    nxt_state = FLUSH_EMIT;
                end
            end
            EMIT: begin
                if (flush) begin
                    nxt_pend = 1'b1;
                end
                if (out_ready) begin
                    nxt_acc   = acc << OUT_W;
                    nxt_fill  = fill - OUT_W_F;
                    nxt_state = nxt_pend ? FLUSH_EMIT : ACCUM;
                end
            end
            FLUSH_EMIT: begin
                // The flush being serviced occupies the single pending slot.
                if (out_ready) begin
                    nxt_acc   = '0;
                    nxt_fill  = '0;
                    nxt_pend  = 1'b0;
                    nxt_state = ACCUM;
                end
            end
            default: begin
                nxt_acc   = '0;
                nxt_fill  = '0;
                nxt_pend  = 1'b0;
                nxt_state = ACCUM;
            end
        endcase

        nxt_in_ready  = (nxt_state == ACCUM) && (nxt_fill < OUT_W_F) && !nxt_pend;
        nxt_out_valid = (nxt_state != ACCUM);
        nxt_out_last  = (nxt_state == FLUSH_EMIT);
        nxt_out_data  = nxt_out_valid ? nxt_acc[ACC_W-1 -: OUT_W] : '0;
        case (nxt_state)
            EMIT:       nxt_out_bits = OUT_W_F;
            FLUSH_EMIT: nxt_out_bits = nxt_fill;
            default:    nxt_out_bits = '0;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state      <= ACCUM;
            acc        <= '0;
            fill       <= '0;
            flush_pend <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            out_bits   <= '0;
        end else begin
            state      <= nxt_state;
            acc        <= nxt_acc;
            fill       <= nxt_fill;
            flush_pend <= nxt_pend;
            in_ready   <= nxt_in_ready;
            out_valid  <= nxt_out_valid;
            out_data   <= nxt_out_data;
            out_last   <= nxt_out_last;
            out_bits   <= nxt_out_bits;
        end
    end

`ifdef PACK_STATS_EN
    logic [15:0] bit_cnt;
    logic [15:0] cnt_inc;

    assign cnt_inc = accept ? sat_add16(bit_cnt, 16'(len_eff)) : bit_cnt;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            bit_cnt    <= '0;
            frame_bits <= '0;
        end else if ((state == FLUSH_EMIT) && out_ready) begin
            frame_bits <= cnt_inc;
            bit_cnt    <= '0;
        end else begin
            bit_cnt    <= cnt_inc;
        end
    end
`endif

endmodule
